// File: rtl/measure_rx_parser_pkg.sv
// rtl/measure_rx_parser_pkg.sv - XGMII characters, header constants and helpers for the RX parser
package measure_rx_parser_pkg;

  localparam logic [7:0]  XGMII_START    = 8'hfb;
  localparam logic [7:0]  XGMII_TERM     = 8'hfd;
  localparam logic [7:0]  XGMII_ERR      = 8'hfe;

  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [31:0] DEF_MAGIC_CODE = 32'h4d45_4153;

  // Word index 7 carries the last timestamp bytes; the header is complete after it.
  localparam logic [3:0]  HDR_LAST_WORD  = 4'd7;
  localparam logic [3:0]  WORD_IDX_MAX   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  function automatic logic [7:0] lane_byte(input logic [63:0] word, input logic [2:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hffff_ffff : sum[31:0];
  endfunction

endpackage

// File: rtl/measure_rx_parser_if.sv
// rtl/measure_rx_parser_if.sv - 64-bit XGMII receive bus
interface measure_rx_parser_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/measure_rx_parser.sv
// rtl/measure_rx_parser.sv - qualifies IPv4/UDP measurement frames on XGMII RX and reports per-second stats
module measure_rx_parser
  import measure_rx_parser_pkg::*;
#(
  parameter logic [31:0] MAGIC_CODE = DEF_MAGIC_CODE,
  parameter logic [15:0] UDP_DPORT  = 16'h0900,
  parameter int          LAT_WIDTH  = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 sec_oneshot,
  input  logic [31:0]          global_counter,
  measure_rx_parser_if.slave   xgmii,
  output logic [31:0]          rx_pps,
  output logic [31:0]          rx_throughput,
  output logic [LAT_WIDTH-1:0] rx_latency,
  output logic [31:0]          rx_ipv4_ip,
  output logic [15:0]          rx_err_count
);

  localparam logic [31:0] LAT_MAX = 32'((64'd1 << LAT_WIDTH) - 64'd1);

  logic [63:0]          rd;
  logic [7:0]           rc;
  rx_state_t            state_q, state_d;
  logic [3:0]           w_q, cur_w;
  logic                 is_start, any_err, term_hit, hdr_bad;
  logic [2:0]           first_lane;
  logic [15:0]          frame_len;
  logic                 commit, err_inc;
  logic [15:0]          ip_hi_q, ts_hi_q;
  logic [31:0]          ip_q, ts_full, diff;
  logic [LAT_WIDTH-1:0] lat_q, lat_sat;
  logic [31:0]          pps_acc, byte_acc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd <= '0;
      rc <= '0;
    end else begin
      rd <= xgmii.xgmii_rxd;
      rc <= xgmii.xgmii_rxc;
    end
  end

  assign is_start = (rc == 8'h01) && (rd[7:0] == XGMII_START);
  assign cur_w    = (w_q == WORD_IDX_MAX) ? WORD_IDX_MAX : w_q + 4'd1;

  // Length comes from the lowest control lane; termination/error may sit in any control lane.
  always_comb begin
    any_err    = 1'b0;
    term_hit   = 1'b0;
    first_lane = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rc[k]) begin
        first_lane = 3'(k);
        if (lane_byte(rd, 3'(k)) == XGMII_ERR)  any_err  = 1'b1;
        if (lane_byte(rd, 3'(k)) == XGMII_TERM) term_hit = 1'b1;
      end
    end
  end

  assign frame_len = {9'd0, cur_w - 4'd1, first_lane};

  always_comb begin
    hdr_bad = 1'b0;
    case (cur_w)
      4'd2: hdr_bad = ({lane_byte(rd, 3'd4), lane_byte(rd, 3'd5)} != ETH_TYPE_IPV4) ||
                      (lane_byte(rd, 3'd6) != IPV4_VER_IHL);
      4'd3: hdr_bad = lane_byte(rd, 3'd7) != IP_PROTO_UDP;
      4'd5: hdr_bad = {lane_byte(rd, 3'd4), lane_byte(rd, 3'd5)} != UDP_DPORT;
      4'd6: hdr_bad = {lane_byte(rd, 3'd2), lane_byte(rd, 3'd3),
                       lane_byte(rd, 3'd4), lane_byte(rd, 3'd5)} != MAGIC_CODE;
      default: hdr_bad = 1'b0;
    endcase
  end

  assign ts_full = {ts_hi_q, lane_byte(rd, 3'd0), lane_byte(rd, 3'd1)};
  assign diff    = global_counter - ts_full;
  assign lat_sat = (diff > LAT_MAX) ? LAT_MAX[LAT_WIDTH-1:0] : diff[LAT_WIDTH-1:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    err_inc = 1'b0;
    if (is_start) begin
      state_d = ST_HDR;
      err_inc = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_HDR: begin
          if (term_hit) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end else if (any_err || hdr_bad) begin
            state_d = ST_DROP;
          end else if (cur_w == HDR_LAST_WORD) begin
            state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          if (term_hit) begin
            state_d = ST_IDLE;
            err_inc = any_err;
            commit  = !any_err;
          end else if (any_err) begin
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (term_hit) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_q           <= '0;
      ip_hi_q       <= '0;
      ip_q          <= '0;
      ts_hi_q       <= '0;
      lat_q         <= '0;
      pps_acc       <= '0;
      byte_acc      <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
      rx_latency    <= '0;
      rx_ipv4_ip    <= '0;
      rx_err_count  <= '0;
    end else begin
      w_q <= is_start ? 4'd0 : cur_w;

      if (state_q == ST_HDR && !is_start) begin
        if (cur_w == 4'd4) ip_hi_q <= {lane_byte(rd, 3'd6), lane_byte(rd, 3'd7)};
        if (cur_w == 4'd5) ip_q    <= {ip_hi_q, lane_byte(rd, 3'd0), lane_byte(rd, 3'd1)};
        if (cur_w == 4'd6) ts_hi_q <= {lane_byte(rd, 3'd6), lane_byte(rd, 3'd7)};
        if (cur_w == HDR_LAST_WORD) lat_q <= lat_sat;
      end

      if (commit) begin
        rx_latency <= lat_q;
        rx_ipv4_ip <= ip_q;
      end

      if (err_inc) rx_err_count <= rx_err_count + 16'd1;

      // A frame committing on the window edge is credited to the new window.
      if (sec_oneshot) begin
        rx_pps        <= pps_acc;
        rx_throughput <= byte_acc;
        pps_acc       <= commit ? 32'd1 : 32'd0;
        byte_acc      <= commit ? {16'd0, frame_len} : 32'd0;
      end else if (commit) begin
        pps_acc       <= sat_add32(pps_acc, 32'd1);
        byte_acc      <= sat_add32(byte_acc, {16'd0, frame_len});
      end
    end
  end

endmodule
